// File: rtl/mux_pkg.sv
// ============================================================================
// Module : mux_pkg
// Brief  : Shared constants and helpers for the arbitrated multiplexer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_pkg;

    localparam logic MODO_FIXO   = 1'b0;
    localparam logic MODO_RR     = 1'b1;
    // Widest word paridade_par accepts; narrower words are zero-extended.
    localparam int   LARGURA_MAX = 256;

    function automatic int proximo_indice(input int idx, input int n);
        return (n <= 1) ? 0 : ((idx + 1) % n);
    endfunction

    function automatic logic paridade_par(input logic [LARGURA_MAX-1:0] word);
        return ^word;
    endfunction

endpackage

`default_nettype wire

// File: rtl/arbitro_rr.sv
// ============================================================================
// Module : arbitro_rr
// Brief  : Combinational round-robin picker: first valid channel at or after
//          ponteiro, wrapping at NUM_ENTRADAS-1.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbitro_rr
    import mux_pkg::*;
#(
    parameter  int NUM_ENTRADAS = 4,
    localparam int SEL_W        = (NUM_ENTRADAS > 1) ? $clog2(NUM_ENTRADAS) : 1
) (
    input  logic [NUM_ENTRADAS-1:0] valido,
    input  logic [SEL_W-1:0]        ponteiro,
    input  logic                    habilita,
    output logic [NUM_ENTRADAS-1:0] concessao,
    output logic [SEL_W-1:0]        vencedor
);

    int w_dist;
    int w_melhor;
    int w_sel;

    // Winner is the valid channel with the smallest forward distance from ponteiro.
    always_comb begin
        w_dist    = 0;
        w_melhor  = NUM_ENTRADAS;
        w_sel     = 0;
        concessao = '0;
        for (int i = 0; i < NUM_ENTRADAS; i++) begin
            w_dist = (i + NUM_ENTRADAS - int'(ponteiro)) % NUM_ENTRADAS;
            if (habilita && valido[i] && (w_dist < w_melhor)) begin
                w_melhor = w_dist;
                w_sel    = i;
            end
        end
        for (int i = 0; i < NUM_ENTRADAS; i++) begin
            concessao[i] = (w_melhor < NUM_ENTRADAS) && (w_sel == i);
        end
        vencedor = SEL_W'(w_sel);
    end

endmodule

`default_nettype wire

// File: rtl/mux_arbitrado_param.sv
// ============================================================================
// Module : mux_arbitrado_param
// Brief  : N-input registered mux with valid/ready handshake, fixed or
//          round-robin selection. Optional parity output: MUX_PARIDADE_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_arbitrado_param
    import mux_pkg::*;
#(
    parameter  int NUM_ENTRADAS = 4,
    parameter  int LARGURA      = 8,
    localparam int SEL_W        = (NUM_ENTRADAS > 1) ? $clog2(NUM_ENTRADAS) : 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_ENTRADAS*LARGURA-1:0] entradas,
    input  logic [NUM_ENTRADAS-1:0]         valido,
    output logic [NUM_ENTRADAS-1:0]         aceito,
    input  logic                            modo,
    input  logic [SEL_W-1:0]                selecao,
    output logic [LARGURA-1:0]              saida,
    output logic                            saida_valida,
    output logic [SEL_W-1:0]                canal_saida,
    input  logic                            pronto_saida,
    output logic                            saida_paridade
);

    logic [LARGURA-1:0]      r_saida;
    logic                    r_saida_valida;
    logic [SEL_W-1:0]        r_canal;
    logic [SEL_W-1:0]        r_ponteiro;

    logic                    w_carregar;
    logic                    w_hab_rr;
    logic [NUM_ENTRADAS-1:0] w_conc_rr;
    logic [SEL_W-1:0]        w_venc_rr;
    logic [NUM_ENTRADAS-1:0] w_aceito;
    logic [LARGURA-1:0]      w_dado;
    logic                    w_conceder;
    logic [SEL_W-1:0]        w_vencedor;

    // One-entry pipeline: a held word may drain on the same edge a new one loads.
    assign w_carregar = !r_saida_valida || pronto_saida;
    assign w_hab_rr   = w_carregar && (modo == MODO_RR) && !reset;

    arbitro_rr #(
        .NUM_ENTRADAS (NUM_ENTRADAS)
    ) u_arbitro_rr (
        .valido    (valido),
        .ponteiro  (r_ponteiro),
        .habilita  (w_hab_rr),
        .concessao (w_conc_rr),
        .vencedor  (w_venc_rr)
    );

    always_comb begin
        w_aceito = '0;
        w_dado   = '0;
        if (!reset && w_carregar) begin
            if (modo == MODO_RR) begin
                w_aceito = w_conc_rr;
            end else begin
                // Out-of-range selecao matches no channel, so it never grants.
                for (int i = 0; i < NUM_ENTRADAS; i++) begin
                    w_aceito[i] = valido[i] && (int'(selecao) == i);
                end
            end
        end
        for (int i = 0; i < NUM_ENTRADAS; i++) begin
            if (w_aceito[i]) begin
                w_dado = entradas[i*LARGURA +: LARGURA];
            end
        end
    end

    assign w_conceder = |w_aceito;
    assign w_vencedor = (modo == MODO_RR) ? w_venc_rr : selecao;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_saida        <= '0;
            r_saida_valida <= 1'b0;
            r_canal        <= '0;
            r_ponteiro     <= '0;
        end else if (w_conceder) begin
            r_saida        <= w_dado;
            r_canal        <= w_vencedor;
            r_saida_valida <= 1'b1;
            if (modo == MODO_RR) begin
                r_ponteiro <= SEL_W'(proximo_indice(int'(w_vencedor), NUM_ENTRADAS));
            end
        end else if (w_carregar) begin
            r_saida_valida <= 1'b0;
        end
    end

`ifdef MUX_PARIDADE_EN
    logic r_paridade;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_paridade <= 1'b0;
        end else if (w_conceder) begin
            r_paridade <= paridade_par(LARGURA_MAX'(w_dado));
        end
    end

    assign saida_paridade = r_paridade;
`else
    assign saida_paridade = 1'b0;
`endif

    assign aceito       = w_aceito;
    assign saida        = r_saida;
    assign saida_valida = r_saida_valida;
    assign canal_saida  = r_canal;

endmodule

`default_nettype wire

// File: tb/tb_mux_arbitrado_param.sv
// ============================================================================
// Module : tb_mux_arbitrado_param
// Brief  : Self-checking bench for mux_arbitrado_param (N=4, LARGURA=8).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mux_arbitrado_param;

    localparam int N  = 4;
    localparam int L  = 8;
    localparam int SW = 2;

    logic           clock = 1'b0;
    logic           reset;
    logic [N*L-1:0] entradas;
    logic [N-1:0]   valido;
    logic [N-1:0]   aceito;
    logic           modo;
    logic [SW-1:0]  selecao;
    logic [L-1:0]   saida;
    logic           saida_valida;
    logic [SW-1:0]  canal_saida;
    logic           pronto_saida;
    logic           saida_paridade;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic         m_valid;
    logic [L-1:0] m_saida;
    int           m_canal;
    logic         m_par;
    int           m_ptr;

    mux_arbitrado_param #(
        .NUM_ENTRADAS (N),
        .LARGURA      (L)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .entradas       (entradas),
        .valido         (valido),
        .aceito         (aceito),
        .modo           (modo),
        .selecao        (selecao),
        .saida          (saida),
        .saida_valida   (saida_valida),
        .canal_saida    (canal_saida),
        .pronto_saida   (pronto_saida),
        .saida_paridade (saida_paridade)
    );

    always #5 clock = ~clock;

    // Inputs are set just after a rising edge; grant checked mid-cycle, outputs after the edge.
    task automatic cycle();
        int           w;
        logic         carregar;
        logic [N-1:0] exp_ac;
        logic [L-1:0] word;
        #2;
        carregar = !m_valid || pronto_saida;
        w = -1;
        if (!reset && carregar) begin
            if (modo == 1'b0) begin
                if (int'(selecao) < N && valido[selecao]) w = int'(selecao);
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && valido[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                end
            end
        end
        exp_ac = '0;
        if (w >= 0) exp_ac[w] = 1'b1;
        checks++;
        if (aceito !== exp_ac) begin
            errors++;
            $display("FAIL aceito: got %b expected %b", aceito, exp_ac);
        end
        if (reset) begin
            m_valid = 1'b0; m_saida = '0; m_canal = 0; m_par = 1'b0; m_ptr = 0;
        end else if (w >= 0) begin
            word    = entradas[w*L +: L];
            m_saida = word;
            m_canal = w;
            m_valid = 1'b1;
`ifdef MUX_PARIDADE_EN
            m_par   = ^word;
`endif
            if (modo == 1'b1) m_ptr = (w + 1) % N;
        end else if (carregar) begin
            m_valid = 1'b0;
        end
        @(posedge clock);
        #1;
        checks++;
        if (saida_valida !== m_valid) begin
            errors++;
            $display("FAIL saida_valida: got %b expected %b", saida_valida, m_valid);
        end
        checks++;
        if (saida !== m_saida) begin
            errors++;
            $display("FAIL saida: got %h expected %h", saida, m_saida);
        end
        checks++;
        if (canal_saida !== SW'(m_canal)) begin
            errors++;
            $display("FAIL canal_saida: got %0d expected %0d", canal_saida, m_canal);
        end
        checks++;
        if (saida_paridade !== m_par) begin
            errors++;
            $display("FAIL saida_paridade: got %b expected %b", saida_paridade, m_par);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; modo = 1'b1; valido = 4'b1111; pronto_saida = 1'b1;
        entradas = 32'h44332211; selecao = 2'd0;
        cycle();
        cycle();
        checks++;
        if (saida !== 8'h00 || saida_valida !== 1'b0 || canal_saida !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %h/%b/%0d expected 00/0/0", saida, saida_valida, canal_saida);
        end
        reset = 1'b0;
    endtask

    task automatic test_fixo();
        logic [L-1:0] tab [4] = '{8'h00, 8'h01, 8'h02, 8'h80};
        modo = 1'b0; valido = 4'b1111; pronto_saida = 1'b1;
        entradas = {8'h80, 8'h02, 8'h01, 8'h00};
        for (int s = 0; s < 4; s++) begin
            selecao = SW'(s);
            cycle();
            checks++;
            if (saida !== tab[s] || canal_saida !== SW'(s)) begin
                errors++;
                $display("FAIL fixo_%0d: got %h/%0d expected %h/%0d", s, saida, canal_saida, tab[s], s);
            end
        end
    endtask

    task automatic test_rr_todos();
        int seq [6] = '{0, 1, 2, 3, 0, 1};
        modo = 1'b1; valido = 4'b1111; pronto_saida = 1'b1;
        entradas = 32'hD4C3B2A1;
        for (int c = 0; c < 6; c++) begin
            cycle();
            checks++;
            if (canal_saida !== SW'(seq[c]) || saida_valida !== 1'b1) begin
                errors++;
                $display("FAIL rr_todos_%0d: got %0d/%b expected %0d/1", c, canal_saida, saida_valida, seq[c]);
            end
        end
    endtask

    task automatic test_rr_1010();
        int seq [4] = '{1, 3, 1, 3};
        reset = 1'b1;
        cycle();
        reset = 1'b0; modo = 1'b1; valido = 4'b1010; pronto_saida = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle();
            checks++;
            if (canal_saida !== SW'(seq[c])) begin
                errors++;
                $display("FAIL rr_1010_%0d: got %0d expected %0d", c, canal_saida, seq[c]);
            end
        end
    endtask

    task automatic test_backpressure();
        modo = 1'b0; selecao = 2'd2; valido = 4'b1111; pronto_saida = 1'b1;
        entradas = {8'h80, 8'h02, 8'h01, 8'h00};
        cycle();
        pronto_saida = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            checks++;
            if (saida !== 8'h02 || canal_saida !== 2'd2 || saida_valida !== 1'b1) begin
                errors++;
                $display("FAIL stall_%0d: got %h/%0d expected 02/2", c, saida, canal_saida);
            end
        end
        selecao = 2'd3; pronto_saida = 1'b1;
        cycle();
        checks++;
        if (saida !== 8'h80 || canal_saida !== 2'd3 || saida_valida !== 1'b1) begin
            errors++;
            $display("FAIL drain_load: got %h/%0d expected 80/3", saida, canal_saida);
        end
    endtask

    task automatic test_reset_meio();
        reset = 1'b1;
        cycle();
        reset = 1'b0; modo = 1'b1; valido = 4'b0010; pronto_saida = 1'b1;
        entradas = 32'h11223344;
        cycle();
        pronto_saida = 1'b0; reset = 1'b1;
        cycle();
        checks++;
        if (saida_valida !== 1'b0 || saida !== 8'h00) begin
            errors++;
            $display("FAIL reset_meio: got %b/%h expected 0/00", saida_valida, saida);
        end
        reset = 1'b0; valido = 4'b1111; pronto_saida = 1'b1;
        cycle();
        checks++;
        if (canal_saida !== 2'd0) begin
            errors++;
            $display("FAIL rr_pos_reset: got %0d expected 0", canal_saida);
        end
    endtask

    task automatic test_paridade();
        logic exp1, exp2;
`ifdef MUX_PARIDADE_EN
        exp1 = 1'b1; exp2 = 1'b0;
`else
        exp1 = 1'b0; exp2 = 1'b0;
`endif
        modo = 1'b0; selecao = 2'd0; valido = 4'b0001; pronto_saida = 1'b1;
        entradas = 32'h000000FF;
        cycle();
        entradas = 32'h00000007;
        cycle();
        checks++;
        if (saida_paridade !== exp1) begin
            errors++;
            $display("FAIL paridade_07: got %b expected %b", saida_paridade, exp1);
        end
        entradas = 32'h00000003;
        cycle();
        checks++;
        if (saida_paridade !== exp2) begin
            errors++;
            $display("FAIL paridade_03: got %b expected %b", saida_paridade, exp2);
        end
    endtask

    task automatic test_aleatorio();
        for (int c = 0; c < 400; c++) begin
            reset        = ($urandom_range(0, 39) == 0);
            modo         = 1'($urandom);
            selecao      = SW'($urandom);
            valido       = N'($urandom);
            pronto_saida = ($urandom_range(0, 3) != 0);
            entradas     = $urandom;
            cycle();
        end
        reset = 1'b0;
    endtask

    initial begin
        m_valid = 1'b0; m_saida = '0; m_canal = 0; m_par = 1'b0; m_ptr = 0;
        test_reset();
        test_fixo();
        test_rr_todos();
        test_rr_1010();
        test_backpressure();
        test_reset_meio();
        test_paridade();
        test_aleatorio();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
